// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package irq_ctrl_pkg;

  localparam int DEF_N_SRC   = 6;
  localparam int DEF_HOLDOFF = 4;

  // Word addresses of the register window
  localparam logic [31:0] ADDR_PEND = 32'h0000_7F20;
  localparam logic [31:0] ADDR_MASK = 32'h0000_7F24;
  localparam logic [31:0] ADDR_MODE = 32'h0000_7F28;
  localparam logic [31:0] ADDR_ID   = 32'h0000_7F2C;

  // Interrupt-line handshake with the CPU
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending sources.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask/mode registers on the CPU data bus,
// per-source edge or level capture, and a CPU interrupt line with holdoff.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byteen,
  output logic [31:0]      rdata,
  output logic             cpu_int
);

  // A holdoff of zero would never leave HOLD sensibly, so it behaves as one
  localparam int HOLD_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;
  localparam int CNT_W    = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);

  logic [31:0]      word_addr;
  logic             sel_pend, sel_mask, sel_mode, sel_id;
  logic             ack;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg, mode_reg, prev_reg;
  logic [N_SRC-1:0] set_vec, clr_vec, active;
  logic             any_active, id_valid;
  logic [2:0]       id_idx;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             int_reg;

  // Only byte lane 0 carries register bits, and upper data bits are don't-care
  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[31:N_SRC], byteen[3:1]};

  assign word_addr = addr & 32'hFFFF_FFFC;
  assign sel_pend  = (word_addr == ADDR_PEND);
  assign sel_mask  = (word_addr == ADDR_MASK);
  assign sel_mode  = (word_addr == ADDR_MODE);
  assign sel_id    = (word_addr == ADDR_ID);
  assign ack       = sel_pend & byteen[0];

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      // Edge sources fire on a 0->1 transition, level sources whenever high
      assign set_vec[gi] = mode_reg[gi] ? (src_irq[gi] & ~prev_reg[gi]) : src_irq[gi];
    end
  endgenerate

  // A new event on a bit wins over a simultaneous write-one-to-clear
  assign clr_vec    = ack ? wdata[N_SRC-1:0] : '0;
  assign pend_next  = (pend_reg & ~clr_vec) | set_vec;
  assign active     = pend_reg & mask_reg;
  assign any_active = |active;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req   (active),
    .valid (id_valid),
    .idx   (id_idx)
  );

  // Interrupt handshake: raise, drop on acknowledge, then hold off briefly
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_active) state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (ack) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end else if (!any_active) begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register file, source sampling and FSM state
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_reg  <= '0;
      mask_reg  <= '1;
      mode_reg  <= '0;
      prev_reg  <= '0;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      int_reg   <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      prev_reg  <= src_irq;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      int_reg   <= (state_next == ST_ASSERT);
      if (sel_mask && byteen[0]) mask_reg <= wdata[N_SRC-1:0];
      if (sel_mode && byteen[0]) mode_reg <= wdata[N_SRC-1:0];
    end
  end

  assign cpu_int = int_reg;

  // Read mux: window registers, zero everywhere else
  always_comb begin
    rdata = 32'd0;
    if (sel_pend)      rdata = {{(32 - N_SRC){1'b0}}, pend_reg};
    else if (sel_mask) rdata = {{(32 - N_SRC){1'b0}}, mask_reg};
    else if (sel_mode) rdata = {{(32 - N_SRC){1'b0}}, mode_reg};
    else if (sel_id)   rdata = {28'd0, id_valid, id_idx};
  end

endmodule
